and_gate: RTL and testbench

AND_GATE -- requirements
Module: and_gate

---
 rtl/and_gate_pkg.sv | 22 ++
 rtl/and_gate_sat_cnt.sv | 44 ++++
 rtl/and_gate.sv | 114 +++++++++++
 tb/tb_and_gate.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the and_gate block.
// Holds the default operand/counter widths and the saturation-limit function
// used to size the match counter's ceiling.
package and_gate_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // All-ones value of a w-bit counter, returned in a 64-bit container.
    // Counters wider than 64 bits are not supported.
    function automatic logic [63:0] sat_max(input int w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/and_gate_sat_cnt.sv
// Saturating up-counter used to count all-ones results in and_gate.
// Increments by one per cycle with inc_i high, sticks at its maximum value,
// and clears on the synchronous active-high rst.
module and_gate_sat_cnt
    import and_gate_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [63:0]      MAX_WIDE = sat_max(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = MAX_WIDE[CNT_W-1:0];

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: hold by default, step up only while below the ceiling.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a combinational output and a valid-qualified registered
// path (result, reduction-AND, reduction-OR), plus a saturating count of
// all-ones results.
// Optional feature: define AND_GATE_PARITY_EN to register the XOR-reduction
// of each captured result on y_parity; otherwise y_parity is tied to 0.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic             out_valid,
    output logic [WIDTH-1:0] y_q,
    output logic             all_ones,
    output logic             any_one,
    output logic [CNT_W-1:0] match_count,
    output logic             y_parity
);

    logic [WIDTH-1:0] and_res;
    logic             res_all_ones;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             all_ones_q;
    logic             all_ones_d;
    logic             any_one_q;
    logic             any_one_d;
    logic             valid_q;
    logic             valid_d;

    // The combinational result never depends on clk or rst.
    assign and_res      = a & b;
    assign res_all_ones = &and_res;
    assign y            = and_res;

    // Capture on every valid cycle (no backpressure), otherwise hold the
    // last result; out_valid simply follows in_valid one cycle later.
    always_comb begin
        res_d      = res_q;
        all_ones_d = all_ones_q;
        any_one_d  = any_one_q;
        valid_d    = in_valid;
        if (in_valid) begin
            res_d      = and_res;
            all_ones_d = res_all_ones;
            any_one_d  = |and_res;
        end
    end

    // Result registers; reset takes priority over a same-cycle valid input.
    always_ff @(posedge clk) begin
        // NOTE: rst is checked first inside the clocked block, which makes it
        // synchronous and lets it discard any input presented with it.
        if (rst) begin
            res_q      <= '0;
            all_ones_q <= 1'b0;
            any_one_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            res_q      <= res_d;
            all_ones_q <= all_ones_d;
            any_one_q  <= any_one_d;
            valid_q    <= valid_d;
        end
    end

    assign y_q       = res_q;
    assign all_ones  = all_ones_q;
    assign any_one   = any_one_q;
    assign out_valid = valid_q;

    and_gate_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (in_valid & res_all_ones),
        .count_o (match_count)
    );

`ifdef AND_GATE_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity of the captured result, loaded with the same timing as res_q.
    always_comb begin
        parity_d = parity_q;
        if (in_valid) begin
            parity_d = ^and_res;
        end
    end

    // Parity register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign y_parity = parity_q;
`else
    assign y_parity = 1'b0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: three instances (WIDTH=1; WIDTH=8 with
// the default counter; WIDTH=8 with a 2-bit counter) driven from directed
// vectors with hand-computed expectations.
module tb_and_gate;

`ifdef AND_GATE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       a1;
    logic       b1;

    // WIDTH=8, CNT_W=16 instance
    logic [7:0]  y8, yq8;
    logic        ov8, all8, any8, par8;
    logic [15:0] cnt8;

    // WIDTH=8, CNT_W=2 instance
    logic [7:0]  yc, yqc;
    logic        ovc, allc, anyc, parc;
    logic [1:0]  cntc;

    // WIDTH=1 instance
    logic        y1, yq1, ov1, all1, any1, par1;
    logic [15:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    and_gate #(.WIDTH(8), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .y(y8), .in_valid(in_valid),
        .out_valid(ov8), .y_q(yq8), .all_ones(all8), .any_one(any8),
        .match_count(cnt8), .y_parity(par8)
    );

    and_gate #(.WIDTH(8), .CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .y(yc), .in_valid(in_valid),
        .out_valid(ovc), .y_q(yqc), .all_ones(allc), .any_one(anyc),
        .match_count(cntc), .y_parity(parc)
    );

    and_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .in_valid(in_valid),
        .out_valid(ov1), .y_q(yq1), .all_ones(all1), .any_one(any1),
        .match_count(cnt1), .y_parity(par1)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_yq;
        logic       exp_all;
        logic       exp_any;
        logic       exp_ov;
        int         exp_cnt;
        int         exp_cnt2;
        logic       exp_par;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_y1;
        exp_y1 = 4'b1000;

        //            valid a      b      yq     all   any   ov   cnt cnt2 par
        vecs[0] = '{1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8'h30, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
        vecs[3] = '{1'b1, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
        vecs[4] = '{1'b1, 8'h07, 8'hFF, 8'h07, 1'b0, 1'b1, 1'b1, 1, 1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h07, 1'b0, 1'b1, 1'b0, 1, 1, 1'b1};
        vecs[6] = '{1'b1, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
        vecs[7] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 2, 2, 1'b0};
        vecs[8] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 2, 2, 1'b0};
        vecs[9] = '{1'b1, 8'hFE, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b1, 2, 2, 1'b1};

        // Combinational truth table, before the first clock edge, with rst held.
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 8'hF0;
        b        = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #1;
            check($sformatf("y1 ab=%0d%0d", a1, b1), {31'd0, y1}, {31'd0, exp_y1[i]});
        end
        check("y8 comb under rst", {24'd0, y8}, 32'h30);

        // Reset state.
        tick();
        tick();
        check("rst yq8",   {24'd0, yq8},  32'h0);
        check("rst all8",  {31'd0, all8}, 32'h0);
        check("rst any8",  {31'd0, any8}, 32'h0);
        check("rst ov8",   {31'd0, ov8},  32'h0);
        check("rst cnt8",  {16'd0, cnt8}, 32'h0);
        check("rst par8",  {31'd0, par8}, 32'h0);
        check("rst cntc",  {30'd0, cntc}, 32'h0);
        check("rst yq1",   {31'd0, yq1},  32'h0);

        // Directed vector table.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].valid;
            a        = vecs[i].a;
            b        = vecs[i].b;
            tick();
            check($sformatf("v%0d yq", i),   {24'd0, yq8},  {24'd0, vecs[i].exp_yq});
            check($sformatf("v%0d all", i),  {31'd0, all8}, {31'd0, vecs[i].exp_all});
            check($sformatf("v%0d any", i),  {31'd0, any8}, {31'd0, vecs[i].exp_any});
            check($sformatf("v%0d ov", i),   {31'd0, ov8},  {31'd0, vecs[i].exp_ov});
            check($sformatf("v%0d cnt", i),  {16'd0, cnt8}, vecs[i].exp_cnt);
            check($sformatf("v%0d cnt2", i), {30'd0, cntc}, vecs[i].exp_cnt2);
            check($sformatf("v%0d par", i),  {31'd0, par8},
                  {31'd0, PAR_EN & vecs[i].exp_par});
        end

        // Counter run: six all-ones inputs; the 2-bit counter sticks at 3.
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("sat cntc after %0d", i), {30'd0, cntc}, (i < 3) ? i : 3);
            if (i == 5) begin
                check("5x cnt8", {16'd0, cnt8}, 32'd5);
                check("5x all8", {31'd0, all8}, 32'd1);
            end
        end
        check("6x cnt8", {16'd0, cnt8}, 32'd6);
        in_valid = 1'b0;
        tick();
        check("sat hold cntc", {30'd0, cntc}, 32'd3);
        check("idle ov8",      {31'd0, ov8},  32'd0);
        check("idle cnt8",     {16'd0, cnt8}, 32'd6);

        // Reset together with a valid all-ones input: reset wins.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        tick();
        check("rw yq8",     {24'd0, yq8},  32'h0);
        check("rw all8",    {31'd0, all8}, 32'h0);
        check("rw any8",    {31'd0, any8}, 32'h0);
        check("rw ov8",     {31'd0, ov8},  32'h0);
        check("rw cnt8",    {16'd0, cnt8}, 32'h0);
        check("rw cntc",    {30'd0, cntc}, 32'h0);
        check("rw par8",    {31'd0, par8}, 32'h0);
        check("rw y8 comb", {24'd0, y8},   32'hFF);

        // Parity of 0x07 & 0xFF = 0x07 -> three ones -> odd.
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = 8'h07;
        b        = 8'hFF;
        tick();
        check("par 07", {31'd0, par8}, {31'd0, PAR_EN});
        check("par 07 yq", {24'd0, yq8}, 32'h07);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
